// File: rtl/axis_wb_pkg.sv
// ----------------------------------------------------------------------------
// axis_wb_pkg
// Shared definitions for the AXI-Stream to Wishbone frame writer.
//   state_e    : frame FSM encoding (IDLE=0, RUN=1, FLUSH=2)
//   WB_SEL_ALL : all-ones byte-select source; sliced to DATA_W/8 by the user
// ----------------------------------------------------------------------------
package axis_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int unsigned WB_SEL_MAX_W = 128;
    localparam logic [WB_SEL_MAX_W-1:0] WB_SEL_ALL = '1;

endpackage

// File: rtl/axis_wb_fifo.sv
// ----------------------------------------------------------------------------
// axis_wb_fifo
// Synchronous show-ahead FIFO buffering stream words ahead of the Wishbone
// master. Push on full and pop on empty are ignored.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write wdata_i this cycle
//   pop_i        : drop the head entry this cycle
//   wdata_i      : write data
//   rdata_o      : current head entry (valid when !empty_o)
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
// ----------------------------------------------------------------------------
module axis_wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/axis_wb_writer.sv
// ----------------------------------------------------------------------------
// axis_wb_writer
// Captures one AXI-Stream frame per start pulse and writes each word to
// consecutive Wishbone addresses starting at base_addr. Words past MAX_WORDS
// are accepted but dropped and raise the sticky err flag.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   start, base_addr        : arm a capture, first write address
//   ss_tvalid/tready/tdata/tlast : AXI-Stream slave
//   wbm_cyc_o/stb_o/we_o/adr_o/dat_o/sel_o, wbm_ack_i : Wishbone master
//   busy, done              : frame in progress, one-cycle completion pulse
//   word_cnt, err           : words written this frame, overflow flag
// Optional (macro AXIS_WB_WRITER_IRQ_EN):
//   irq_clr, irq            : sticky interrupt set by done, clear has priority
// ----------------------------------------------------------------------------
module axis_wb_writer
    import axis_wb_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_WORDS  = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_W-1:0]                base_addr,
    input  logic                             ss_tvalid,
    output logic                             ss_tready,
    input  logic [DATA_W-1:0]                ss_tdata,
    input  logic                             ss_tlast,
    output logic                             wbm_cyc_o,
    output logic                             wbm_stb_o,
    output logic                             wbm_we_o,
    output logic [ADDR_W-1:0]                wbm_adr_o,
    output logic [DATA_W-1:0]                wbm_dat_o,
    output logic [DATA_W/8-1:0]              wbm_sel_o,
    input  logic                             wbm_ack_i,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(MAX_WORDS+1)-1:0]   word_cnt,
    output logic                             err
`ifdef AXIS_WB_WRITER_IRQ_EN
    ,
    input  logic                             irq_clr,
    output logic                             irq
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(DATA_W / 8);

    state_e            state_q;
    logic              cyc_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] dat_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic              err_q;
    logic              done_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              ss_fire;
    logic              push;
    logic              wb_ack;
    logic              wb_launch;

    assign ss_tready = (state_q == RUN) && !fifo_full;
    assign ss_fire   = ss_tvalid && ss_tready;
    // Beats past the frame limit still handshake but never enter the FIFO.
    assign push      = ss_fire && (beat_cnt_q < MAX_CNT);
    // An ack is only meaningful while the strobe is up.
    assign wb_ack    = cyc_q && wbm_ack_i;
    // Launch only from a dropped cycle, which forces one idle cycle per write.
    assign wb_launch = !cyc_q && !fifo_empty;

    axis_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (wb_ack),
        .wdata_i (ss_tdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cyc_q      <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            word_cnt_q <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        adr_q      <= base_addr;
                        word_cnt_q <= '0;
                        beat_cnt_q <= '0;
                        err_q      <= 1'b0;
                    end
                end
                RUN: begin
                    if (ss_fire) begin
                        if (beat_cnt_q < MAX_CNT) beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        else                      err_q      <= 1'b1;
                        if (ss_tlast) state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (fifo_empty && !cyc_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // The FIFO is always empty in IDLE, so no ack can collide with
            // the base_addr load above.
            if (wb_launch) begin
                cyc_q <= 1'b1;
                dat_q <= fifo_rdata;
            end else if (wb_ack) begin
                cyc_q      <= 1'b0;
                adr_q      <= adr_q + ADDR_INC;
                word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
        end
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = cyc_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = WB_SEL_ALL[DATA_W/8-1:0];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign word_cnt  = word_cnt_q;
    assign err       = err_q;

`ifdef AXIS_WB_WRITER_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       irq_q <= 1'b0;
        else if (irq_clr) irq_q <= 1'b0;
        else if (done_q)  irq_q <= 1'b1;
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_axis_wb_writer.sv
// ----------------------------------------------------------------------------
// tb_axis_wb_writer
// Self-checking bench for axis_wb_writer: stream driver, Wishbone slave with
// programmable ack delay, and a scoreboard of expected {address, data} writes.
// Interrupt checks are included when AXIS_WB_WRITER_IRQ_EN is defined.
// ----------------------------------------------------------------------------
module tb_axis_wb_writer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic        ss_tvalid;
    logic        ss_tready;
    logic [31:0] ss_tdata;
    logic        ss_tlast;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i;
    logic        busy;
    logic        done;
    logic [6:0]  word_cnt;
    logic        err;
`ifdef AXIS_WB_WRITER_IRQ_EN
    logic        irq_clr;
    logic        irq;
`endif

    axis_wb_writer #(
        .DATA_W     (32),
        .ADDR_W     (32),
        .FIFO_DEPTH (4),
        .MAX_WORDS  (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .ss_tvalid (ss_tvalid),
        .ss_tready (ss_tready),
        .ss_tdata  (ss_tdata),
        .ss_tlast  (ss_tlast),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_ack_i (wbm_ack_i),
        .busy      (busy),
        .done      (done),
        .word_cnt  (word_cnt),
        .err       (err)
`ifdef AXIS_WB_WRITER_IRQ_EN
        ,
        .irq_clr   (irq_clr),
        .irq       (irq)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [63:0] sb [$];
    logic [31:0] frame_base;
    int unsigned beat_idx;
    int unsigned ack_delay;
    int unsigned wait_cnt;
    bit          stray_ack;
    int unsigned done_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wishbone slave and write scoreboard; all decisions made on the falling edge.
    always @(negedge clk) begin
        logic [63:0] exp;
        if (!rst_n) begin
            wbm_ack_i = 1'b0;
            wait_cnt  = 0;
        end else if (wbm_ack_i) begin
            wbm_ack_i = 1'b0;
        end else if (wbm_stb_o) begin
            if (wait_cnt >= ack_delay) begin
                wbm_ack_i = 1'b1;
                wait_cnt  = 0;
                if (sb.size() == 0) begin
                    check("sb_unexpected_write", 64'(wbm_adr_o), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp = sb.pop_front();
                    check("wb_adr", 64'(wbm_adr_o), 64'(exp[63:32]));
                    check("wb_dat", 64'(wbm_dat_o), 64'(exp[31:0]));
                    check("wb_we_sel", 64'({wbm_cyc_o, wbm_we_o, wbm_sel_o}), 64'h3F);
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            if (stray_ack) wbm_ack_i = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic start_frame(input logic [31:0] base);
        base_addr  = base;
        start      = 1'b1;
        frame_base = base;
        beat_idx   = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        int unsigned guard = 0;
        ss_tvalid = 1'b1;
        ss_tdata  = d;
        ss_tlast  = last;
        while (!ss_tready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (!ss_tready) begin
            check("tready_timeout", 64'(ss_tready), 64'd1);
        end else begin
            if (beat_idx < 64) sb.push_back({frame_base + 32'(beat_idx * 4), d});
            beat_idx++;
            @(negedge clk);
        end
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
    endtask

    task automatic wait_done(input int unsigned exp_cnt, input logic exp_err);
        int unsigned guard = 0;
        int unsigned d0;
        d0 = done_cnt;
        while (!done && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", 64'(done), 64'd1);
        @(negedge clk);
        @(negedge clk);
        check("done_once", 64'(done_cnt - d0), 64'd1);
        check("word_cnt", 64'(word_cnt), 64'(exp_cnt));
        check("err", 64'(err), 64'(exp_err));
        check("busy_after", 64'(busy), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int unsigned guard;
        int unsigned d0;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        ss_tvalid = 1'b0;
        ss_tdata  = '0;
        ss_tlast  = 1'b0;
        wbm_ack_i = 1'b0;
        ack_delay = 0;
        wait_cnt  = 0;
        stray_ack = 1'b0;
        done_cnt  = 0;
        frame_base = '0;
        beat_idx  = 0;
`ifdef AXIS_WB_WRITER_IRQ_EN
        irq_clr   = 1'b0;
`endif

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cyc_stb_we", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 64'd0);
        check("rst_tready", 64'(ss_tready), 64'd0);
        check("rst_adr_dat", {wbm_adr_o, wbm_dat_o}, 64'd0);
        check("rst_busy_done_err", 64'({busy, done, err}), 64'd0);
        check("rst_word_cnt", 64'(word_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Stray acks with no strobe must not disturb anything
        stray_ack = 1'b1;
        repeat (4) @(negedge clk);
        stray_ack = 1'b0;
        @(negedge clk);
        check("stray_idle_cnt", 64'(word_cnt), 64'd0);
        check("stray_idle_cyc", 64'(wbm_cyc_o), 64'd0);

        // Basic 4-word frame, ack one cycle after strobe, mid-frame start ignored
        ack_delay = 1;
        start_frame(32'h3000_0000);
        check("busy_run", 64'(busy), 64'd1);
        send_beat(32'h11, 1'b0);
        send_beat(32'h22, 1'b0);
        base_addr = 32'h5000_0000;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        send_beat(32'h33, 1'b0);
        send_beat(32'h44, 1'b1);
        check("tready_after_last", 64'(ss_tready), 64'd0);
        @(negedge clk);
        check("tready_flush", 64'(ss_tready), 64'd0);
        wait_done(4, 1'b0);

        // Single-beat frame and ingress-to-strobe latency
        ack_delay = 0;
        start_frame(32'h0000_1000);
        send_beat(32'hAB, 1'b1);
        check("lat_stb_early", 64'(wbm_stb_o), 64'd0);
        @(negedge clk);
        check("lat_stb_2cyc", 64'(wbm_stb_o), 64'd1);
        wait_done(1, 1'b0);

        // Slow slave: FIFO fills after 4 words, order preserved
        ack_delay = 10;
        start_frame(32'h0000_8000);
        for (int i = 0; i < 4; i++) send_beat(32'hA0 + 32'(i), 1'b0);
        check("backpressure_full", 64'(ss_tready), 64'd0);
        for (int i = 4; i < 8; i++) send_beat(32'hA0 + 32'(i), i == 7);
        wait_done(8, 1'b0);

        // Address wraps modulo 2^32, stray acks between writes ignored
        ack_delay = 0;
        stray_ack = 1'b1;
        start_frame(32'hFFFF_FFFC);
        send_beat(32'hC0DE_0001, 1'b0);
        send_beat(32'hC0DE_0002, 1'b1);
        wait_done(2, 1'b0);
        stray_ack = 1'b0;

        // Overflow: 70 beats, only 64 written
        start_frame(32'h0000_2000);
        for (int i = 0; i < 70; i++) send_beat(32'h1000 + 32'(i), i == 69);
        wait_done(64, 1'b1);

        // Reset while a write waits for ack
        ack_delay = 1000;
        start_frame(32'h0000_6000);
        send_beat(32'h77, 1'b0);
        guard = 0;
        while (!wbm_stb_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("rst_mid_stb_seen", 64'(wbm_stb_o), 64'd1);
        @(negedge clk);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("rst_mid_cyc", 64'(wbm_cyc_o), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_cnt", 64'(word_cnt), 64'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
        ack_delay = 1;
        start_frame(32'h0000_4000);
        send_beat(32'hD1, 1'b0);
        send_beat(32'hD2, 1'b1);
        wait_done(2, 1'b0);

`ifdef AXIS_WB_WRITER_IRQ_EN
        // irq sets after done, is cleared by irq_clr, and clear beats a same-cycle set
        check("irq_pending", 64'(irq), 64'd1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("irq_cleared", 64'(irq), 64'd0);
        ack_delay = 0;
        start_frame(32'h0000_9000);
        send_beat(32'hE1, 1'b1);
        guard = 0;
        while (!done && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("irq_done_seen", 64'(done), 64'd1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("irq_clr_wins", 64'(irq), 64'd0);
        @(negedge clk);
        check("irq_stays_low", 64'(irq), 64'd0);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_wb_writer.md
AXIS_WB_WRITER -- requirements
Module: axis_wb_writer

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, stream and Wishbone data width; ADDR_W, 32, Wishbone address width; FIFO_DEPTH, 4, ingress buffer words (power of 2, >=2); MAX_WORDS, 64, frame word limit.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse; arms a frame capture.
REQ-005 base_addr  input  ADDR_W  first Wishbone write address, sampled on accepted start.
REQ-006 ss_tvalid / ss_tready / ss_tdata / ss_tlast  input / output / input[DATA_W] / input  AXI-Stream slave carrying samples from the FIR.
REQ-007 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone master cycle, strobe, write-enable.
REQ-008 wbm_adr_o  output  ADDR_W;  wbm_dat_o  output  DATA_W;  wbm_sel_o  output  DATA_W/8  (all ones).
REQ-009 wbm_ack_i  input  1  Wishbone slave acknowledge.
REQ-010 busy  output  1  frame in progress;  done  output  1  one-cycle completion pulse.
REQ-011 word_cnt  output  $clog2(MAX_WORDS+1)  words written in current/last frame;  err  output  1  sticky overflow flag.

Function
REQ-012 FSM states SHALL be IDLE, RUN, FLUSH; start in IDLE -> RUN (latch base_addr, clear word_cnt and err); start in RUN/FLUSH ignored.
REQ-013 ss_tready SHALL be 1 only in RUN with FIFO not full; a beat transfers on ss_tvalid & ss_tready; push on a full FIFO never occurs, even with a same-cycle pop.
REQ-014 Accepted beat with ss_tlast=1 SHALL move RUN -> FLUSH; no further beats accepted until next start.
REQ-015 Beats beyond MAX_WORDS in a frame SHALL still be accepted (ss_tready per REQ-013) but discarded, and set err.
REQ-016 Wishbone side: when FIFO non-empty and no cycle active, next cycle assert cyc=stb=we=1 with adr=current address, dat=FIFO head; hold all stable until wbm_ack_i.
REQ-017 On ack: pop FIFO, deassert cyc/stb the following cycle (min one idle cycle between writes), address += DATA_W/8 modulo 2^ADDR_W, word_cnt += 1.
REQ-018 wbm_ack_i while stb=0 SHALL be ignored.
REQ-019 FLUSH -> IDLE when FIFO empty and no cycle active; done pulses 1 cycle in that transition cycle+1; busy=1 in RUN and FLUSH.
REQ-020 Frame with tlast on first beat SHALL write exactly one word; latency ss beat accepted (empty FIFO, idle bus) -> stb asserted = 2 cycles.

Reset
REQ-021 rst_n low SHALL immediately force: IDLE, FIFO empty, ss_tready=0, cyc=stb=we=0, adr=0, dat=0, busy=0, done=0, word_cnt=0, err=0.
REQ-022 Reset mid-cycle SHALL abandon the Wishbone transfer (cyc dropped) and discard buffered data; no done pulse.

Configuration
REQ-023 Macro AXIS_WB_WRITER_IRQ_EN defined: add output irq (1 bit) set on done, cleared by input irq_clr (1 bit), clr wins on simultaneous set; undefined: neither port exists, no irq logic.

Structure
REQ-024 Package axis_wb_pkg SHALL hold FSM state encoding (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2) and WB_SEL_ALL constant.
REQ-025 FIFO SHALL be sub-module axis_wb_fifo (sync, DEPTH, WIDTH, full/empty, push/pop); rest in axis_wb_writer.

Verification
REQ-026 base_addr=0x3000_0000, start, 4 beats 0x11..0x44 last on 4th, ack 1 cycle after stb -> writes 0x11@0x3000_0000 ... 0x44@0x3000_000C, word_cnt=4, one done pulse.
REQ-027 Ack held off 10 cycles, 8 back-to-back beats -> ss_tready low after 4 buffered, no data loss, order preserved.
REQ-028 MAX_WORDS=64, 70-beat frame -> 64 writes, err=1, done pulses, word_cnt=64.
REQ-029 base_addr=0xFFFF_FFFC, 2 beats -> second write at 0x0000_0000.
REQ-030 rst_n low while stb waiting ack -> cyc=0 same cycle, busy=0, no done; next frame after start writes correctly.
REQ-031 With AXIS_WB_WRITER_IRQ_EN: irq rises after done, irq_clr and done same cycle -> irq=0.
